intersect_monitor: RTL

INTERSECT_MONITOR -- requirements
Module: intersect_monitor

---
 rtl/intersect_monitor.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/intersect_monitor.sv
// Single-attempt monitor for A |=> ((B ##1 !B[*] ##1 B) intersect (C[*] ##1 D)) ##1 B ##1 C ##1 D.
// Define INTERSECT_MONITOR_STATS_EN to add saturating pass_count/fail_count outputs.
`timescale 1ns/1ps

module intersect_monitor #(
    parameter int unsigned MAX_LEN = 31
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       A,
    input  logic       B,
    input  logic       C,
    input  logic       D,
    output logic       pass,
    output logic       fail,
    output logic [2:0] fail_code,
    output logic       busy,
    output logic       overrun,
    output logic [7:0] len
`ifdef INTERSECT_MONITOR_STATS_EN
    ,
    output logic [15:0] pass_count,
    output logic [15:0] fail_count
`endif
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] MID    = 3'd2;
    localparam logic [2:0] POST_B = 3'd3;
    localparam logic [2:0] POST_C = 3'd4;
    localparam logic [2:0] POST_D = 3'd5;

    localparam logic [7:0] MAX_GAP = 8'(MAX_LEN);

    logic [2:0] state_q,     state_d;
    logic [7:0] gap_q,       gap_d;
    logic [7:0] len_pend_q,  len_pend_d;
    logic [7:0] len_q,       len_d;
    logic [2:0] fail_code_q, fail_code_d;
    logic       pass_q,      pass_d;
    logic       fail_q,      fail_d;
    logic       overrun_q,   overrun_d;

    // NOTE: every variable gets a default before the case so no path infers a latch.
    always_comb begin
        state_d     = state_q;
        gap_d       = gap_q;
        len_pend_d  = len_pend_q;
        len_d       = len_q;
        fail_code_d = fail_code_q;
        pass_d      = 1'b0;
        fail_d      = 1'b0;
        overrun_d   = A && (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (A) begin
                    state_d = START;
                    gap_d   = 8'd0;
                end
            end
            START: begin
                if (B && C) begin
                    state_d = MID;
                end else begin
                    fail_d      = 1'b1;
                    fail_code_d = 3'd1;
                end
            end
            MID: begin
                if (B) begin
                    // Length is only published once the whole sequence passes.
                    if (D) begin
                        state_d    = POST_B;
                        len_pend_d = gap_q + 8'd1;
                    end else begin
                        fail_d      = 1'b1;
                        fail_code_d = 3'd3;
                    end
                end else if (C) begin
                    if (gap_q < MAX_GAP) begin
                        gap_d = gap_q + 8'd1;
                    end else begin
                        fail_d      = 1'b1;
                        fail_code_d = 3'd7;
                    end
                end else begin
                    fail_d      = 1'b1;
                    fail_code_d = 3'd2;
                end
            end
            POST_B: begin
                if (B) begin
                    state_d = POST_C;
                end else begin
                    fail_d      = 1'b1;
                    fail_code_d = 3'd4;
                end
            end
            POST_C: begin
                if (C) begin
                    state_d = POST_D;
                end else begin
                    fail_d      = 1'b1;
                    fail_code_d = 3'd5;
                end
            end
            POST_D: begin
                if (D) begin
                    pass_d = 1'b1;
                    len_d  = len_pend_q;
                end else begin
                    fail_d      = 1'b1;
                    fail_code_d = 3'd6;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (pass_d || fail_d) begin
            state_d = IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            gap_q       <= 8'd0;
            len_pend_q  <= 8'd0;
            len_q       <= 8'd0;
            fail_code_q <= 3'd0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            gap_q       <= gap_d;
            len_pend_q  <= len_pend_d;
            len_q       <= len_d;
            fail_code_q <= fail_code_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef INTERSECT_MONITOR_STATS_EN
    logic [15:0] pass_count_q;
    logic [15:0] fail_count_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            pass_count_q <= 16'd0;
            fail_count_q <= 16'd0;
        end else begin
            if (pass_d && (pass_count_q != 16'hFFFF)) begin
                pass_count_q <= pass_count_q + 16'd1;
            end
            if (fail_d && (fail_count_q != 16'hFFFF)) begin
                fail_count_q <= fail_count_q + 16'd1;
            end
        end
    end

    assign pass_count = pass_count_q;
    assign fail_count = fail_count_q;
`endif

    assign pass      = pass_q;
    assign fail      = fail_q;
    assign fail_code = fail_code_q;
    assign busy      = (state_q != IDLE);
    assign overrun   = overrun_q;
    assign len       = len_q;

endmodule
